// File: rtl/ads5296_tx_serializer.sv
// ads5296_tx_serializer
// Emulates the ADS5296 LVDS output stream for board loopback and receiver
// bring-up. Each lane sends a 10-bit word MSB-first over 5 lclk cycles as
// DDR rise/fall bit pairs. A matching frame-clock pair is also driven, so
// external ODDRE1/OBUFDS primitives can drive the pins.
//
// Ports:
//   lclk           line (bit) clock, DDR; the only clock
//   rst_n          asynchronous active-low reset
//   en             transmit enable (low: zero words, fclk keeps running)
//   sync           single-cycle realign pulse
//   pattern_sel    0=data 1=const 2=ramp 3=deskew 4=sync 5-7=zeros
//   const_word     word sent on all lanes in const mode
//   din            parallel words, lane k at [10k+9:10k]
//   din_valid      din holds a valid frame
//   din_ready      frame accepted this cycle when din_valid is also high
//   dout_rise      per-lane bit for the rising edge of lclk
//   dout_fall      per-lane bit for the falling edge of lclk
//   fclk_rise      frame clock bit for the rising edge
//   fclk_fall      frame clock bit for the falling edge
//   frame_start    high in phase-0 cycles
//   underflow      sticky data-starvation flag
//   underflow_clr  clears underflow (a simultaneous set wins)
module ads5296_tx_serializer #(
  parameter int G_NUM_LANES = 8,
  parameter int RAMP_STEP   = 1
) (
  input  logic                      lclk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      sync,
  input  logic [2:0]                pattern_sel,
  input  logic [9:0]                const_word,
  input  logic [10*G_NUM_LANES-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [G_NUM_LANES-1:0]    dout_rise,
  output logic [G_NUM_LANES-1:0]    dout_fall,
  output logic                      fclk_rise,
  output logic                      fclk_fall,
  output logic                      frame_start,
  output logic                      underflow,
  input  logic                      underflow_clr
);

  typedef enum logic [2:0] {
    PAT_DATA   = 3'd0,
    PAT_CONST  = 3'd1,
    PAT_RAMP   = 3'd2,
    PAT_DESKEW = 3'd3,
    PAT_SYNC   = 3'd4
  } pat_e;

  localparam logic [2:0] PH_LOAD = 3'd4;

  logic [2:0]                  phase, phase_nxt;
  logic                        load;
  logic [9:0]                  ramp_cnt, ramp_nxt;
  logic                        underflow_nxt;
  logic [G_NUM_LANES-1:0][9:0] shreg, shreg_nxt;
  logic [G_NUM_LANES-1:0][9:0] word_sel;
  logic [G_NUM_LANES-1:0]      rise_nxt, fall_nxt;
  logic                        fclk_rise_nxt, fclk_fall_nxt, frame_start_nxt;

  assign load      = (phase == PH_LOAD);
  assign din_ready = en & (pattern_sel == PAT_DATA) & load;

  // State register: all outputs are registered so the pins see clean edges.
  always_ff @(posedge lclk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= PH_LOAD;
      ramp_cnt    <= '0;
      underflow   <= 1'b0;
      shreg       <= '0;
      dout_rise   <= '0;
      dout_fall   <= '0;
      fclk_rise   <= 1'b0;
      fclk_fall   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      ramp_cnt    <= ramp_nxt;
      underflow   <= underflow_nxt;
      shreg       <= shreg_nxt;
      dout_rise   <= rise_nxt;
      dout_fall   <= fall_nxt;
      fclk_rise   <= fclk_rise_nxt;
      fclk_fall   <= fclk_fall_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  // Next-state: phase, ramp counter and sticky underflow.
  always_comb begin
    phase_nxt     = phase;
    ramp_nxt      = ramp_cnt;
    underflow_nxt = underflow;

    if (sync)      phase_nxt = PH_LOAD;
    else if (load) phase_nxt = 3'd0;
    else           phase_nxt = phase + 3'd1;

    if (sync)             ramp_nxt = '0;
    else if (load && en)  ramp_nxt = ramp_cnt + 10'(RAMP_STEP);

    if (din_ready && !din_valid) underflow_nxt = 1'b1;
    else if (underflow_clr)      underflow_nxt = 1'b0;
  end

  // Word selection for the load cycle.
  always_comb begin
    word_sel = '0;
    for (int unsigned k = 0; k < G_NUM_LANES; k++) begin
      if (en) begin
        case (pattern_sel)
          PAT_DATA:   word_sel[k] = din_valid ? din[10*k +: 10] : 10'h000;
          PAT_CONST:  word_sel[k] = const_word;
          PAT_RAMP:   word_sel[k] = ramp_cnt + 10'(k);
          PAT_DESKEW: word_sel[k] = 10'b1010101010;
          PAT_SYNC:   word_sel[k] = 10'b1111100000;
          default:    word_sel[k] = 10'h000;
        endcase
      end
    end
  end

  // Output values for the coming cycle. The outputs are computed for
  // phase_nxt, so a word loaded now shows its MSB pair in phase 0 and the
  // shift register keeps only the bits still to be sent. A sync in the load
  // cycle skips the load, discarding that word.
  always_comb begin
    shreg_nxt = '0;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int unsigned k = 0; k < G_NUM_LANES; k++) begin
      if (load && !sync) begin
        rise_nxt[k]  = word_sel[k][9];
        fall_nxt[k]  = word_sel[k][8];
        shreg_nxt[k] = {word_sel[k][7:0], 2'b00};
      end else begin
        rise_nxt[k]  = shreg[k][9];
        fall_nxt[k]  = shreg[k][8];
        shreg_nxt[k] = {shreg[k][7:0], 2'b00};
      end
    end
    // Five bit-times high then five low, rising edge aligned to bit 9.
    fclk_rise_nxt   = (phase_nxt <= 3'd2);
    fclk_fall_nxt   = (phase_nxt <= 3'd1);
    frame_start_nxt = (phase_nxt == 3'd0);
  end

endmodule

// File: tb/tb_ads5296_tx_serializer.sv
module tb_ads5296_tx_serializer;
  localparam int N    = 8;
  localparam int STEP = 1;

  typedef logic [N-1:0][9:0] frame_t;

  logic            lclk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            sync;
  logic [2:0]      pattern_sel;
  logic [9:0]      const_word;
  logic [10*N-1:0] din;
  logic            din_valid;
  logic            din_ready;
  logic [N-1:0]    dout_rise;
  logic [N-1:0]    dout_fall;
  logic            fclk_rise;
  logic            fclk_fall;
  logic            frame_start;
  logic            underflow;
  logic            underflow_clr;

  ads5296_tx_serializer #(.G_NUM_LANES(N), .RAMP_STEP(STEP)) dut (
    .lclk(lclk), .rst_n(rst_n), .en(en), .sync(sync),
    .pattern_sel(pattern_sel), .const_word(const_word), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .dout_rise(dout_rise),
    .dout_fall(dout_fall), .fclk_rise(fclk_rise), .fclk_fall(fclk_fall),
    .frame_start(frame_start), .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  always #5 lclk = ~lclk;

  int         n_vec = 0;
  int         n_err = 0;
  int         tp;
  logic [9:0] m_ramp;
  logic       m_uf;
  logic       dchk;
  frame_t     cur_w;
  frame_t     exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h tp=%0d t=%0t", tag, obs, exp, tp, $time);
    end
  endtask

  task automatic model_reset();
    tp     = 4;
    m_ramp = '0;
    m_uf   = 1'b0;
    dchk   = 1'b1;
    cur_w  = '0;
    exp_q.delete();
  endtask

  task automatic randomize_din();
    for (int k = 0; k < N; k++) din[10*k +: 10] = 10'($urandom);
  endtask

  // One lclk cycle: predict from the inputs in force, then check the
  // registered outputs shortly after the edge.
  task automatic cycle();
    frame_t       w;
    logic [N-1:0] er, ef;
    #1;
    chk("din_ready", din_ready, en && pattern_sel == 3'd0 && tp == 4);
    if (tp == 4 && !sync) begin
      for (int k = 0; k < N; k++) begin
        if (!en) w[k] = 10'h000;
        else case (pattern_sel)
          3'd0:    w[k] = din_valid ? din[10*k +: 10] : 10'h000;
          3'd1:    w[k] = const_word;
          3'd2:    w[k] = m_ramp + 10'(k);
          3'd3:    w[k] = 10'h2AA;
          3'd4:    w[k] = 10'h3E0;
          default: w[k] = 10'h000;
        endcase
      end
      exp_q.push_back(w);
    end
    if (tp == 4 && en && pattern_sel == 3'd0 && !din_valid) m_uf = 1'b1;
    else if (underflow_clr) m_uf = 1'b0;
    if (sync) m_ramp = '0;
    else if (tp == 4 && en) m_ramp = m_ramp + 10'(STEP);
    if (sync) begin
      tp   = 4;
      dchk = 1'b0;
    end else begin
      tp = (tp == 4) ? 0 : tp + 1;
    end

    @(posedge lclk);
    #1;
    if (tp == 0) begin
      chk("queue_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        cur_w = exp_q.pop_front();
        dchk  = 1'b1;
      end
    end
    chk("fclk_rise", fclk_rise, tp <= 2);
    chk("fclk_fall", fclk_fall, tp <= 1);
    chk("frame_start", frame_start, tp == 0);
    chk("underflow", underflow, m_uf);
    if (dchk) begin
      for (int k = 0; k < N; k++) begin
        er[k] = cur_w[k][9-2*tp];
        ef[k] = cur_w[k][8-2*tp];
      end
      chk("dout_rise", dout_rise, er);
      chk("dout_fall", dout_fall, ef);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < 10 && tp != ph; i++) cycle();
    chk("run_to_phase", tp, ph);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout_rise"}, dout_rise, '0);
    chk({tag, "_dout_fall"}, dout_fall, '0);
    chk({tag, "_fclk"}, {fclk_rise, fclk_fall}, 2'b00);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
    chk({tag, "_underflow"}, underflow, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; pattern_sel = 3'd0;
    const_word = '0; din = '0; din_valid = 1'b0; underflow_clr = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(posedge lclk); @(posedge lclk); #3;
    chk_all_zero("reset_held");
    rst_n = 1'b1;

    // Sync pattern: each lane mirrors the frame clock.
    en = 1'b1; pattern_sel = 3'd4;
    run(20);

    // Data mode with lane 0 fixed at 10'h2D5, other lanes changing every cycle.
    pattern_sel = 3'd0; din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      randomize_din();
      din[9:0] = 10'h2D5;
      cycle();
    end

    // Underflow: one starved load, hold, clear, then clear colliding with set.
    run_to(4);
    din_valid = 1'b0;
    cycle();
    din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin randomize_din(); cycle(); end
    run_to(1);
    underflow_clr = 1'b1;
    cycle();
    underflow_clr = 1'b0;
    run(5);
    run_to(4);
    din_valid = 1'b0; underflow_clr = 1'b1;
    cycle();
    din_valid = 1'b1; underflow_clr = 1'b0;
    run(7);

    // Asynchronous reset in phase 2 of a deskew frame.
    pattern_sel = 3'd3;
    run(6);
    run_to(2);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge lclk); #2;
    chk_all_zero("async_reset_edge");
    rst_n = 1'b1;
    model_reset();
    run(10);

    // Const mode; the word changes mid-frame and only affects the next frame.
    pattern_sel = 3'd1;
    for (int i = 0; i < 15; i++) begin
      const_word = 10'($urandom);
      cycle();
    end

    // Ramp with en low: zero frames, counter holds.
    pattern_sel = 3'd2;
    run(5);
    en = 1'b0;
    run(15);
    en = 1'b1;
    run(10);

    // Sync mid-frame at phase 1, then sync in a load cycle.
    run_to(1);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    run(10);
    run_to(4);
    sync = 1'b1;
    cycle();
    sync = 1'b0;

    // Full ramp wrap.
    run(1030 * 5);

    // Codes 5-7 send zeros.
    for (int s = 5; s < 8; s++) begin
      pattern_sel = 3'(s);
      run(5);
    end
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout: simulation did not finish, limit=2000000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end
endmodule
